// File: rtl/uart_proto_pkg.sv
// Shared UART framing definitions: frame markers, CRC polynomial and receiver state encoding.
package uart_proto_pkg;

    localparam logic [7:0]  FRAME_HEADER = 8'h80;
    localparam logic [7:0]  FRAME_TAIL   = 8'h55;
    localparam logic [7:0]  CRC8_POLY    = 8'h07;
    localparam int unsigned MAX_PAYLOAD  = 11;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_PAYLOAD = 4'd1,
        ST_CRC     = 4'd2,
        ST_TAIL    = 4'd3
    } rx_state_e;

    // One byte of CRC-8 (MSB first, no reflection, no final XOR).
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_protocol_rx_if.sv
// Byte stream from the UART receiver into the framing stage.
interface uart_protocol_rx_if;

    logic       uart_rx_done;
    logic [7:0] uart_rx_data;

    modport master (output uart_rx_done, output uart_rx_data);
    modport slave  (input  uart_rx_done, input  uart_rx_data);

endinterface

// File: rtl/crc8.sv
// Running CRC-8 accumulator shared by the receive and transmit framing paths.
module crc8
    import uart_proto_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       crc_en,
    input  logic       crc_clr,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_out <= 8'h00;
        end else if (crc_clr) begin
            crc_out <= 8'h00;
        end else if (crc_en) begin
            crc_out <= crc8_step(crc_out, data_in);
        end
    end

endmodule

// File: rtl/uart_protocol_rx.sv
// Frame hunter for 0x80 / payload / CRC8 / 0x55 command frames; latches good payloads into rev_data*.
module uart_protocol_rx
    import uart_proto_pkg::*;
#(
    parameter int unsigned PAYLOAD_LEN    = 3,
    parameter logic [7:0]  HEADER         = FRAME_HEADER,
    parameter logic [7:0]  TAIL           = FRAME_TAIL,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                clk_50M,
    input  logic                rst_n,
    uart_protocol_rx_if.slave   rx_bus,
    output logic [7:0]          rev_data0,
    output logic [7:0]          rev_data1,
    output logic [7:0]          rev_data2,
    output logic [7:0]          rev_data3,
    output logic [7:0]          rev_data4,
    output logic [7:0]          rev_data5,
    output logic [7:0]          rev_data6,
    output logic [7:0]          rev_data7,
    output logic [7:0]          rev_data8,
    output logic [7:0]          rev_data9,
    output logic [7:0]          rev_data10,
    output logic                recv_done,
    output logic                crc_err,
    output logic                tail_err,
    output logic                timeout_err,
    output logic                busy
);

    localparam int unsigned IDX_W = $clog2(MAX_PAYLOAD);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    rx_state_e        state_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] tmo_q;
    logic [7:0]       shadow_q [MAX_PAYLOAD];
    logic [7:0]       rev_q    [MAX_PAYLOAD];
    logic [7:0]       crc_out;

    logic       done_c;
    logic [7:0] data_c;
    logic       crc_en_c;
    logic       crc_clr_c;
    logic       tmo_hit_c;

    assign done_c    = rx_bus.uart_rx_done;
    assign data_c    = rx_bus.uart_rx_data;
    assign crc_en_c  = done_c && (state_q == ST_PAYLOAD);
    assign crc_clr_c = done_c && (state_q == ST_IDLE) && (data_c == HEADER);
    // Fires on the edge where the counter would reach its terminal value; a coincident byte wins.
    assign tmo_hit_c = (state_q != ST_IDLE) && !done_c && (tmo_q == CNT_W'(TIMEOUT_CYCLES - 2));

    crc8 u_crc8 (
        .clk     (clk_50M),
        .rst_n   (rst_n),
        .crc_en  (crc_en_c),
        .crc_clr (crc_clr_c),
        .data_in (data_c),
        .crc_out (crc_out)
    );

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            tmo_q       <= '0;
            recv_done   <= 1'b0;
            crc_err     <= 1'b0;
            tail_err    <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            for (int i = 0; i < MAX_PAYLOAD; i++) begin
                shadow_q[i] <= 8'h00;
                rev_q[i]    <= 8'h00;
            end
        end else begin
            recv_done   <= 1'b0;
            crc_err     <= 1'b0;
            tail_err    <= 1'b0;
            timeout_err <= 1'b0;

            if (done_c || (state_q == ST_IDLE)) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + CNT_W'(1);
            end

            if (tmo_hit_c) begin
                state_q     <= ST_IDLE;
                timeout_err <= 1'b1;
                busy        <= 1'b0;
                tmo_q       <= '0;
            end else if (done_c) begin
                case (state_q)
                    ST_IDLE: begin
                        if (data_c == HEADER) begin
                            state_q <= ST_PAYLOAD;
                            idx_q   <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    ST_PAYLOAD: begin
                        shadow_q[idx_q] <= data_c;
                        if (idx_q == IDX_W'(PAYLOAD_LEN - 1)) begin
                            state_q <= ST_CRC;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                    ST_CRC: begin
                        if (data_c == crc_out) begin
                            state_q <= ST_TAIL;
                        end else begin
                            state_q <= ST_IDLE;
                            crc_err <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end
                    ST_TAIL: begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                        if (data_c == TAIL) begin
                            recv_done <= 1'b1;
                            for (int i = 0; i < MAX_PAYLOAD; i++) begin
                                if (i < PAYLOAD_LEN) begin
                                    rev_q[i] <= shadow_q[i];
                                end
                            end
                        end else begin
                            tail_err <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rev_data0  = rev_q[0];
    assign rev_data1  = rev_q[1];
    assign rev_data2  = rev_q[2];
    assign rev_data3  = rev_q[3];
    assign rev_data4  = rev_q[4];
    assign rev_data5  = rev_q[5];
    assign rev_data6  = rev_q[6];
    assign rev_data7  = rev_q[7];
    assign rev_data8  = rev_q[8];
    assign rev_data9  = rev_q[9];
    assign rev_data10 = rev_q[10];

endmodule

// File: doc/uart_protocol_rx.md
Name: uart_protocol_rx

Overview:
- Upstream framing stage of the UART command path: consumes bytes from uart_rx (uart_rx_done/uart_rx_data) and hunts for frames of the form 0x80, PAYLOAD_LEN payload bytes, CRC8, 0x55.
- On a valid frame, updates rev_data0..rev_data10 and pulses recv_done, which drives the response transmitter and the register/DDS control logic.
- Bad CRC, bad tail or inter-byte timeout discard the frame and raise a one-cycle error pulse.

Parameters:
- PAYLOAD_LEN, 3, payload bytes per frame; legal range 1..11.
- HEADER, 8'h80, frame start byte.
- TAIL, 8'h55, frame end byte.
- TIMEOUT_CYCLES, 50000, maximum clk_50M cycles between bytes inside a frame (1 ms).

Ports:
- clk_50M  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset
- uart_rx_done  in  1  one-cycle strobe: uart_rx_data is valid
- uart_rx_data  in  8  received byte
- rev_data0 .. rev_data10  out  8 each (11 ports)  payload bytes of the last good frame, in arrival order
- recv_done  out  1  one-cycle pulse: good frame latched
- crc_err  out  1  one-cycle pulse: CRC mismatch
- tail_err  out  1  one-cycle pulse: byte after the CRC is not TAIL
- timeout_err  out  1  one-cycle pulse: inter-byte timeout
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, active-low) clears all outputs to 0, the state to IDLE, the byte index, the timeout counter and the shadow buffer.
- All outputs are registered. Every state transition happens only on a uart_rx_done cycle, except the timeout transition.
- IDLE:
  - On uart_rx_done with data == HEADER: go to PAYLOAD, idx = 0, pulse crc_clr to the CRC sub-module.
  - Any other byte is dropped silently.
- PAYLOAD:
  - On uart_rx_done: write the byte to shadow[idx] and pulse crc_en with the byte.
  - When idx == PAYLOAD_LEN-1, go to CRC; otherwise idx++.
  - A HEADER value inside the payload is treated as ordinary data (no resync).
- CRC:
  - On uart_rx_done: compare the byte with crc_out.
  - Equal: go to TAIL.
  - Not equal: pulse crc_err and return to IDLE.
- TAIL:
  - On uart_rx_done with data == TAIL: copy shadow[0..PAYLOAD_LEN-1] to rev_data0..; pulse recv_done; return to IDLE.
  - Otherwise: pulse tail_err and return to IDLE.
- Latency: recv_done and the rev_data update occur on the clock edge following the uart_rx_done of the tail byte, i.e. one cycle later. rev_data are stable when recv_done is high.
- rev_data outputs change only on a good frame. Error frames never disturb them. rev_dataN for N >= PAYLOAD_LEN is held at 0.
- Timeout counter:
  - Cleared on every uart_rx_done and while in IDLE; increments otherwise.
  - On reaching TIMEOUT_CYCLES-1 outside IDLE: pulse timeout_err, return to IDLE, clear the counter.
  - If uart_rx_done coincides with the terminal count, the byte wins: it is processed and no timeout is flagged.
- At most one error or done pulse is asserted per cycle.
- The CRC is CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR, computed over the payload bytes only. crc_out is valid one cycle after crc_en; the CRC byte always arrives at least one UART byte time later.
- Back-to-back frames need no gap: a HEADER arriving in the cycle after returning to IDLE is accepted.
- rst_n asserted mid-frame aborts the frame immediately. No pulse is emitted after release.

Decomposition:
- Shared package uart_proto_pkg holds:
  - localparams FRAME_HEADER = 8'h80, FRAME_TAIL = 8'h55, CRC8_POLY = 8'h07, MAX_PAYLOAD = 11;
  - the state encoding IDLE = 0, PAYLOAD = 1, CRC = 2, TAIL = 3 (4-bit).
- Instantiate the existing crc8 module (clk, rst_n, crc_en, crc_clr, data_in, crc_out); the transmitter shares the same CRC definition.
- No other sub-module; the shadow buffer and FSM stay inline.

Test Plan:
- Good frame 80 01 02 03 48 55 with 4340-cycle byte spacing -> one recv_done pulse one cycle after the tail strobe; rev_data0/1/2 = 01/02/03; rev_data3..10 = 00; no errors.
- Same frame with CRC byte 49 -> crc_err pulse on the CRC byte; tail 55 then ignored in IDLE; rev_data unchanged; no recv_done.
- Frame 80 01 02 03 48 AA -> tail_err pulse; rev_data unchanged. Next good frame 80 0A 0B 0C (bench-model CRC) 55 is accepted.
- 80 01 then silence for 50000 cycles -> timeout_err pulse at cycle 49999 after the last strobe; busy drops. A following good frame is accepted.
- Leading garbage 12 55 80 80 02 03 (CRC) 55 -> payload = 80/02/03 (header treated as data); recv_done once.
- rst_n pulsed low after 80 01 -> all outputs 0, state IDLE; the remaining bytes 02 03 48 55 produce no pulses.
